// File: rtl/weight_bram_ctrl.sv
`timescale 1ns/1ps
// weight_bram_ctrl: owns one neuron's weight BRAM port. It sequences a bulk
// weight load and a streamed weight read-out presented as a valid/ready stream.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | waiting for LOAD_START (has priority) or START
// LOAD    | accepting DEPTH load beats; each beat becomes a write next cycle
// WFLUSH  | final registered write is on the BRAM port
// READ    | issuing reads, one per cycle while the output slot is free
// DRAIN   | last word issued; waiting for the MAC to accept it
// FIN     | DONE pulse, then back to IDLE
module weight_bram_ctrl #(
  parameter int DEPTH = 28,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          LOAD_START,
  input  logic          LD_VALID,
  input  logic [DW-1:0] LD_DATA,
  output logic          LD_READY,
  input  logic          START,
  output logic          W_VALID,
  input  logic          W_READY,
  output logic [DW-1:0] W_DATA,
  output logic [AW-1:0] W_INDEX,
  output logic          W_LAST,
  output logic          BUSY,
  output logic          DONE,
  output logic [AW-1:0] BRAM_ADDR,
  output logic [DW-1:0] BRAM_DI,
  output logic          BRAM_EN,
  output logic          BRAM_WE,
  input  logic [DW-1:0] BRAM_DO
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_WFLUSH, S_READ, S_DRAIN, S_FIN
  } state_t;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);
  localparam logic [AW:0]   DEPTH_W  = (AW + 1)'(DEPTH);

  state_t        state;
  logic [AW-1:0] cnt;
  logic          ld_ready_q;
  logic          w_valid_q;
  logic [DW-1:0] w_data_q;
  logic [AW-1:0] w_index_q;
  logic          w_last_q;
  logic          done_q;
  // load writes are registered and presented to the BRAM one cycle after the beat
  logic          wr_en_q;
  logic [AW-1:0] wr_addr_q;
  logic [DW-1:0] wr_data_q;

  logic issue;
  logic beat;

  assign issue = (state == S_READ) && ({1'b0, cnt} < DEPTH_W) && (!w_valid_q || W_READY);
  assign beat  = (state == S_LOAD) && LD_VALID && ld_ready_q;

  assign LD_READY = ld_ready_q;
  assign W_VALID  = w_valid_q;
  assign W_DATA   = w_data_q;
  assign W_INDEX  = w_index_q;
  assign W_LAST   = w_last_q;
  assign DONE     = done_q;
  assign BUSY     = (state != S_IDLE);

  // BRAM port mux: reads come straight from registered state in READ so they
  // settle before the BRAM's negedge; everything else uses the write registers.
  always_comb begin
    BRAM_EN   = wr_en_q;
    BRAM_WE   = wr_en_q;
    BRAM_ADDR = wr_addr_q;
    BRAM_DI   = wr_data_q;
    if (state == S_READ) begin
      BRAM_EN   = issue;
      BRAM_WE   = 1'b0;
      BRAM_ADDR = issue ? cnt : '0;
      BRAM_DI   = '0;
    end
  end

  // sequencer FSM with registered stream, write and status outputs
  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state      <= S_IDLE;
      cnt        <= '0;
      ld_ready_q <= 1'b0;
      w_valid_q  <= 1'b0;
      w_data_q   <= '0;
      w_index_q  <= '0;
      w_last_q   <= 1'b0;
      done_q     <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      done_q    <= 1'b0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      case (state)
        S_IDLE: begin
          if (LOAD_START) begin
            state      <= S_LOAD;
            cnt        <= '0;
            ld_ready_q <= 1'b1;
          end else if (START) begin
            state <= S_READ;
            cnt   <= '0;
          end
        end
        S_LOAD: begin
          if (beat) begin
            wr_en_q   <= 1'b1;
            wr_addr_q <= cnt;
            wr_data_q <= LD_DATA;
            if (cnt == LAST_IDX) begin
              ld_ready_q <= 1'b0;
              state      <= S_WFLUSH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_WFLUSH: begin
          state  <= S_FIN;
          done_q <= 1'b1;
        end
        S_READ: begin
          if (issue) begin
            w_data_q  <= BRAM_DO;
            w_index_q <= cnt;
            w_valid_q <= 1'b1;
            w_last_q  <= (cnt == LAST_IDX);
            // terminal compare ends the stream; the counter is never wrapped
            if (cnt == LAST_IDX) state <= S_DRAIN;
            else                 cnt   <= cnt + 1'b1;
          end else if (w_valid_q && W_READY) begin
            w_valid_q <= 1'b0;
          end
        end
        S_DRAIN: begin
          if (w_valid_q && W_READY) begin
            w_valid_q <= 1'b0;
            state     <= S_FIN;
            done_q    <= 1'b1;
          end
        end
        S_FIN: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/weight_bram_ctrl.md
# weight_bram_ctrl

Sequencer for one neuron's weight BRAM (DEPTH words, negedge-clocked, read-registered, write-first-priority over read). It owns the BRAM port. It arbitrates between a bulk weight load from the host or loader and a streamed weight read-out to the neuron MAC, and it presents the read-out as a valid/ready stream. One instance sits beside each weight BRAM in the ANN layer.

## Interface
- DEPTH, 28: number of weight words; addresses 0..DEPTH-1.
- AW, 5: BRAM address width; DEPTH <= 2^AW.
- DW, 16: weight word width.

- CLK  in  1  clock; all controller registers on posedge; BRAM acts on negedge.
- RSTN  in  1  asynchronous, active-low reset.
- LOAD_START  in  1  pulse in IDLE: begin writing DEPTH words.
- LD_VALID  in  1  load word valid.
- LD_DATA  in  DW  load word.
- LD_READY  out  1  controller accepts load word.
- START  in  1  pulse in IDLE: begin streaming DEPTH weights.
- W_VALID  out  1  W_DATA valid.
- W_READY  in  1  MAC accepts W_DATA.
- W_DATA  out  DW  weight word (registered).
- W_INDEX  out  AW  address of W_DATA.
- W_LAST  out  1  W_DATA is word DEPTH-1.
- BUSY  out  1  state != IDLE.
- DONE  out  1  one-cycle pulse at end of load or stream.
- BRAM_ADDR  out  AW  to BRAM ADDR.
- BRAM_DI  out  DW  to BRAM DI.
- BRAM_EN  out  1  to BRAM EN.
- BRAM_WE  out  1  to BRAM WE.
- BRAM_DO  in  DW  from BRAM DO.

## Operation
- States: IDLE, LOAD, WFLUSH, READ, DRAIN, FIN.
- IDLE:
  - LOAD_START -> LOAD with load counter 0.
  - Else START -> READ with read counter 0.
  - If both arrive in the same cycle, LOAD wins and START is dropped, not queued.
  - START/LOAD_START outside IDLE are ignored.
- LOAD:
  - LD_READY=1.
  - Each LD_VALID&&LD_READY beat registers BRAM_EN=1, BRAM_WE=1, BRAM_ADDR=counter, BRAM_DI=LD_DATA for the next cycle, then increments the counter.
  - The beat with counter=DEPTH-1 goes -> WFLUSH with LD_READY=0.
  - Cycles without a beat drive BRAM_EN=0, BRAM_WE=0.
- WFLUSH: the final write is on the BRAM port this cycle -> FIN.
- READ:
  - Issue condition: counter<DEPTH && (!W_VALID || W_READY).
  - Issue = BRAM_EN=1, BRAM_WE=0, BRAM_ADDR=counter in that cycle. BRAM_ADDR/EN/WE are driven combinationally from registered state, so they are stable before the negedge.
  - At the posedge closing an issue cycle: W_DATA<=BRAM_DO, W_INDEX<=counter, W_VALID<=1, W_LAST<=(counter==DEPTH-1), counter++.
  - At a posedge with W_VALID&&W_READY and no issue: W_VALID<=0.
  - Issuing the word DEPTH-1 -> DRAIN.
- DRAIN: no issues; BRAM_EN=0. On W_VALID&&W_READY -> FIN with W_VALID<=0.
- FIN: DONE=1 for one cycle -> IDLE.
- Backpressure: while W_VALID&&!W_READY, BRAM_EN=0 and W_DATA, W_INDEX, W_LAST are held stable.
- Counter is AW bits and never wraps: the terminal compare at DEPTH-1 ends the sequence.
- BRAM_DI=0 whenever BRAM_WE=0.

## Timing
- Reset, asynchronous: state=IDLE, counters 0, and all of these are 0: LD_READY, W_VALID, W_DATA, W_INDEX, W_LAST, BUSY, DONE, BRAM_EN, BRAM_WE, BRAM_ADDR, BRAM_DI.
- Reset mid-load or mid-stream aborts immediately, with no DONE. A partially loaded BRAM keeps whatever words were already written.
- Read path:
  - START sampled at edge 0. Addr 0 issued in cycle 1; W_VALID=1 in cycle 2.
  - With W_READY held high, word i is valid in cycle 2+i and W_LAST in cycle DEPTH+1.
  - FIN/DONE falls in cycle DEPTH+2; BUSY drops in cycle DEPTH+3.
  - Throughput is 1 word/cycle.
- Load path:
  - Beat k accepted at edge e; the BRAM write occurs at the negedge in cycle e+1.
  - With LD_VALID held high from cycle 1: last beat in cycle DEPTH, WFLUSH in DEPTH+1, DONE in DEPTH+2.
- W_VALID rises only on a posedge and, once high, falls only after acceptance.

## Test plan
- Load ramp: LOAD_START, then 28 beats LD_DATA=0x0100+k with LD_VALID always high -> 28 writes at BRAM_ADDR 0..27, DONE in cycle 30, LD_READY low after the last beat.
- Stream, no stall: START after the ramp load, W_READY=1 -> W_DATA 0x0100..0x011B in cycles 2..29, W_INDEX 0..27, W_LAST only with 0x011B, DONE in cycle 30.
- Backpressure: W_READY low for 3 cycles at index 5 and for 1 cycle at index 27 -> index 5 held 4 cycles with BRAM_EN=0 during the stall, no skipped or duplicated word, 28 words total.
- Collision: LOAD_START and START in the same IDLE cycle, LD_VALID toggling 1/0 -> load performed only, writes on valid beats only, no W_VALID, a single DONE.
- Reset mid-stream: RSTN low at index 10 -> all outputs 0 asynchronously; after release, START streams from index 0 with the loaded data intact.
- Ignored request: START pulse while in LOAD -> no effect; stream begins only on a later START.
